// File: rtl/arm_pkg.sv
// arm_pkg: shared MEM-stage types and constants (FSM encoding, data base address, SRAM halfword width).
package arm_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} mem_state_t;
    localparam int DATA_BASE_DEF = 1024;
    localparam int SRAM_DQ_W = 16;
endpackage

// File: rtl/sram_mem_stage_if.sv
// sram_mem_stage_if: 16-bit asynchronous SRAM pin bundle; master is the MEM stage, slave is the SRAM.
interface sram_mem_stage_if #(parameter int ADDR_W = 18);
    import arm_pkg::*;
    logic [ADDR_W-1:0] sramAddr;
    logic [SRAM_DQ_W-1:0] sramDqOut;
    logic [SRAM_DQ_W-1:0] sramDqIn;
    logic sramDqOe;
    logic sramWeN;
    modport master(output sramAddr, sramDqOut, sramDqOe, sramWeN, input sramDqIn);
    modport slave(input sramAddr, sramDqOut, sramDqOe, sramWeN, output sramDqIn);
endinterface

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable down-counter timing one SRAM halfword phase; done when it reaches zero.
module sram_wait_counter #(
    parameter int W = 1,
    parameter int LOAD = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic ld,
    input  logic en,
    output logic done
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (ld) cnt <= W'(LOAD);
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign done = cnt == '0;
endmodule

// File: rtl/sram_mem_stage.sv
// sram_mem_stage: MEM stage driving a 16-bit async SRAM as two halfword phases per word, freezing the pipeline.
// Optional one-entry read buffer enabled by defining READ_BUF_EN.
module sram_mem_stage
    import arm_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_BASE = DATA_BASE_DEF,
    parameter int SRAM_ADDR_W = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic wbEnIn,
    input  logic memREnIn,
    input  logic memWEnIn,
    input  logic [31:0] aluResIn,
    input  logic [31:0] valRmIn,
    input  logic [3:0] destIn,
    output logic wbEnOut,
    output logic memREnOut,
    output logic [31:0] aluResOut,
    output logic [3:0] destOut,
    output logic [31:0] memData,
    output logic freeze,
    sram_mem_stage_if.master sram
);
    localparam int IW = SRAM_ADDR_W - 1;
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    mem_state_t state;
    logic req, store, load, hit, cnt_done, cnt_ld;
    logic [IW-1:0] widx;
    logic [31:0] hit_data;
    assign wbEnOut = wbEnIn;
    assign memREnOut = memREnIn;
    assign aluResOut = aluResIn;
    assign destOut = destIn;
    assign req = memREnIn | memWEnIn;
    assign store = memWEnIn;
    assign load = memREnIn & ~memWEnIn;
    // word index wraps modulo the SRAM size, so addresses below DATA_BASE alias high words
    assign widx = IW'((aluResIn - 32'(DATA_BASE)) >> 2);
    assign freeze = req & (state != DONE) & ~hit;
    assign cnt_ld = (state == IDLE && req && !hit) || (state == LO && cnt_done);
`ifdef READ_BUF_EN
    logic buf_valid;
    logic [IW-1:0] buf_idx;
    logic [31:0] buf_data;
    assign hit = state == IDLE && load && buf_valid && buf_idx == widx;
    assign hit_data = buf_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_idx <= '0;
            buf_data <= '0;
        end else if (state == DONE && load) begin
            buf_valid <= 1'b1;
            buf_idx <= widx;
            buf_data <= memData;
        end else if (state == DONE && store && buf_valid && buf_idx == widx) begin
            buf_data <= valRmIn;
        end
    end
`else
    assign hit = 1'b0;
    assign hit_data = '0;
`endif
    sram_wait_counter #(.W(CW), .LOAD(WAIT_CYCLES - 1)) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(state == DONE),
        .ld(cnt_ld),
        .en(state == LO || state == HI),
        .done(cnt_done)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            memData <= '0;
            sram.sramAddr <= '0;
            sram.sramDqOut <= '0;
            sram.sramDqOe <= 1'b0;
            sram.sramWeN <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        state <= DONE;
                        memData <= hit_data;
                    end else if (req) begin
                        state <= LO;
                        sram.sramAddr <= {widx, 1'b0};
                        sram.sramDqOut <= valRmIn[15:0];
                        sram.sramDqOe <= store;
                        sram.sramWeN <= ~store;
                    end
                end
                LO: begin
                    if (cnt_done) begin
                        state <= HI;
                        sram.sramAddr <= {widx, 1'b1};
                        sram.sramDqOut <= valRmIn[31:16];
                        if (!store) memData[15:0] <= sram.sramDqIn;
                    end
                end
                HI: begin
                    if (cnt_done) begin
                        state <= DONE;
                        sram.sramDqOe <= 1'b0;
                        sram.sramWeN <= 1'b1;
                        if (!store) memData[31:16] <= sram.sramDqIn;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_mem_stage.sv
// tb_sram_mem_stage: directed checks of the MEM stage against a small behavioural SRAM (WAIT_CYCLES=2).
module tb_sram_mem_stage;
    logic clk = 1'b0;
    logic rst;
    logic wbEnIn, memREnIn, memWEnIn;
    logic [31:0] aluResIn, valRmIn;
    logic [3:0] destIn;
    logic wbEnOut, memREnOut, freeze;
    logic [31:0] aluResOut, memData;
    logic [3:0] destOut;
    logic [15:0] sram [0:15];
    logic [17:0] a_log [0:7];
    logic [15:0] dq_log [0:7];
    logic we_log [0:7];
    logic oe_log [0:7];
    int checks = 0;
    int errors = 0;
    int n;

    sram_mem_stage_if #(.ADDR_W(18)) sif ();

    sram_mem_stage #(.WAIT_CYCLES(2), .DATA_BASE(1024), .SRAM_ADDR_W(18)) dut (
        .clk(clk), .rst(rst), .wbEnIn(wbEnIn), .memREnIn(memREnIn), .memWEnIn(memWEnIn),
        .aluResIn(aluResIn), .valRmIn(valRmIn), .destIn(destIn), .wbEnOut(wbEnOut),
        .memREnOut(memREnOut), .aluResOut(aluResOut), .destOut(destOut), .memData(memData),
        .freeze(freeze), .sram(sif.master)
    );

    always #5 clk = ~clk;

    assign sif.sramDqIn = sram[sif.sramAddr[3:0]];
    always @(posedge clk) if (!sif.sramWeN && sif.sramDqOe) sram[sif.sramAddr[3:0]] <= sif.sramDqOut;

    typedef struct {
        logic wb;
        logic [31:0] alu;
        logic [3:0] dest;
    } vec_t;
    vec_t vecs [0:3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic ren, input logic wen, input logic [31:0] alu, input logic [31:0] val);
        memREnIn = ren;
        memWEnIn = wen;
        aluResIn = alu;
        valRmIn = val;
        wbEnIn = ren;
        destIn = 4'd3;
    endtask

    // presents a request, logs pins for every frozen cycle after the request cycle, returns in DONE
    task automatic run_txn(input logic ren, input logic wen, input logic [31:0] alu, input logic [31:0] val,
                           input logic exp_freeze, output int cyc);
        set_in(ren, wen, alu, val);
        #1;
        chk("freeze_req_cycle", {31'd0, freeze}, {31'd0, exp_freeze});
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!freeze) break;
            if (cyc < 8) begin
                a_log[cyc] = sif.sramAddr;
                dq_log[cyc] = sif.sramDqOut;
                we_log[cyc] = sif.sramWeN;
                oe_log[cyc] = sif.sramDqOe;
            end
            cyc++;
        end
        chk("txn_completes", {31'd0, freeze}, 32'd0);
    endtask

    task automatic go_idle();
        set_in(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) sram[i] = 16'h0;
        sram[2] = 16'h5678;
        sram[3] = 16'h1234;
        vecs[0] = '{1'b1, 32'd7, 4'd5};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 4'd15};
        vecs[2] = '{1'b1, 32'd1028, 4'd0};
        vecs[3] = '{1'b1, 32'h8000_0000, 4'd9};
        rst = 1'b1;
        set_in(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        chk("rst_memData", memData, 32'd0);
        chk("rst_weN", {31'd0, sif.sramWeN}, 32'd1);
        chk("rst_oe", {31'd0, sif.sramDqOe}, 32'd0);
        chk("rst_addr", {14'd0, sif.sramAddr}, 32'd0);
        chk("rst_dqout", {16'd0, sif.sramDqOut}, 32'd0);
        rst = 1'b0;
        tick();

        // non-memory instructions: pure passthrough, no stall, SRAM idle
        for (int i = 0; i < 4; i++) begin
            memREnIn = 1'b0;
            memWEnIn = 1'b0;
            wbEnIn = vecs[i].wb;
            aluResIn = vecs[i].alu;
            destIn = vecs[i].dest;
            valRmIn = 32'hA5A5_A5A5;
            #1;
            chk("alu_pass", aluResOut, vecs[i].alu);
            chk("wb_pass", {31'd0, wbEnOut}, {31'd0, vecs[i].wb});
            chk("dest_pass", {28'd0, destOut}, {28'd0, vecs[i].dest});
            chk("ren_pass", {31'd0, memREnOut}, 32'd0);
            chk("alu_freeze", {31'd0, freeze}, 32'd0);
            tick();
            chk("alu_weN", {31'd0, sif.sramWeN}, 32'd1);
        end

        // load 1028 -> halfwords 2 then 3
        run_txn(1'b1, 1'b0, 32'd1028, 32'd0, 1'b1, n);
        chk("load_freeze_cycles", n, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("load_addr", {14'd0, a_log[i]}, i < 2 ? 32'd2 : 32'd3);
            chk("load_weN", {31'd0, we_log[i]}, 32'd1);
            chk("load_oe", {31'd0, oe_log[i]}, 32'd0);
        end
        chk("load_memData", memData, 32'h1234_5678);
        go_idle();
        chk("load_memData_held", memData, 32'h1234_5678);

        // store 1032 -> halfwords 4 and 5
        run_txn(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 1'b1, n);
        chk("store_freeze_cycles", n, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("store_addr", {14'd0, a_log[i]}, i < 2 ? 32'd4 : 32'd5);
            chk("store_weN", {31'd0, we_log[i]}, 32'd0);
            chk("store_oe", {31'd0, oe_log[i]}, 32'd1);
            chk("store_dq", {16'd0, dq_log[i]}, i < 2 ? 32'h0000_BEEF : 32'h0000_DEAD);
        end
        chk("store_done_weN", {31'd0, sif.sramWeN}, 32'd1);
        chk("store_done_oe", {31'd0, sif.sramDqOe}, 32'd0);
        go_idle();
        chk("sram4", {16'd0, sram[4]}, 32'h0000_BEEF);
        chk("sram5", {16'd0, sram[5]}, 32'h0000_DEAD);
        chk("store_memData", memData, 32'h1234_5678);

        // both enables set -> store
        run_txn(1'b1, 1'b1, 32'd1024, 32'hCAFE_0001, 1'b1, n);
        chk("both_cycles", n, 32'd4);
        chk("both_weN", {31'd0, we_log[0]}, 32'd0);
        go_idle();
        chk("both_sram0", {16'd0, sram[0]}, 32'h0000_0001);
        chk("both_sram1", {16'd0, sram[1]}, 32'h0000_CAFE);
        chk("both_memData", memData, 32'h1234_5678);

        // reset during HI of a store
        set_in(1'b0, 1'b1, 32'd1040, 32'h1111_2222);
        tick();
        tick();
        tick();
        chk("hi_addr", {14'd0, sif.sramAddr}, 32'd9);
        chk("hi_weN", {31'd0, sif.sramWeN}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_hi_weN", {31'd0, sif.sramWeN}, 32'd1);
        chk("rst_hi_oe", {31'd0, sif.sramDqOe}, 32'd0);
        chk("rst_hi_memData", memData, 32'd0);
        chk("rst_hi_freeze_req", {31'd0, freeze}, 32'd1);
        set_in(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("rst_hi_freeze_noreq", {31'd0, freeze}, 32'd0);
        tick();

`ifdef READ_BUF_EN
        run_txn(1'b1, 1'b0, 32'd1028, 32'd0, 1'b1, n);
        chk("buf_first_cycles", n, 32'd4);
        chk("buf_first_data", memData, 32'h1234_5678);
        go_idle();
        run_txn(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, n);
        chk("buf_hit_cycles", n, 32'd0);
        chk("buf_hit_data", memData, 32'h1234_5678);
        go_idle();
        run_txn(1'b0, 1'b1, 32'd1028, 32'd0, 1'b1, n);
        go_idle();
        run_txn(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, n);
        chk("buf_upd_cycles", n, 32'd0);
        chk("buf_upd_data", memData, 32'd0);
        go_idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
